sram_access_scheduler: RTL and testbench

Schedules the single external SRAM port between two requesters: the frame decoder's pixel-fetch path, which has absolute priority whenever video is being fetched, and an auxiliary port used by asset loaders and game logic for reads and writes. Auxiliary accesses are admitted only during fetch-free (blanking) windows. The block inserts drain and bus-turnaround cycles, and registers auxiliary read data. It sits between the frame decoder and the SRAM pins, and adds zero latency to the video path.

---
 rtl/sram_access_scheduler.sv | 122 ++++++++++++
 tb/tb_sram_access_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_scheduler.sv
// Arbitrates the external SRAM port between the video fetch path (absolute priority)
// and an auxiliary read/write port that is served only in fetch-free windows.
module sram_access_scheduler #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vid_req,
    input  logic                  i_vid_soon,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    input  logic                  i_aux_req,
    input  logic                  i_aux_we,
    input  logic [ADDR_WIDTH-1:0] i_aux_addr,
    input  logic [DATA_WIDTH-1:0] i_aux_wdata,
    output logic                  o_aux_gnt,
    output logic                  o_aux_rvalid,
    output logic [DATA_WIDTH-1:0] o_aux_rdata,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    output logic                  o_sram_dq_oe,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata
);

    typedef enum logic [2:0] {
        S_VIDEO,
        S_DRAIN,
        S_IDLE,
        S_AUX_RD,
        S_WR_SETUP,
        S_WR_PULSE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_gnt;
    logic                    w_guard;
    logic                    w_vid_bus;
    logic [ADDR_WIDTH-1:0]   r_aux_addr;
    logic [DATA_WIDTH-1:0]   r_aux_wdata;
    logic [DATA_WIDTH-1:0]   r_aux_rdata;
    logic                    r_rvalid;
    logic                    r_err;

    // Video showing up while an aux access owns the bus is a protocol violation.
    assign w_guard = i_vid_req & ((r_state == S_AUX_RD) | (r_state == S_WR_SETUP) |
                                  (r_state == S_WR_PULSE));

    // Video owns the bus in VIDEO and, for zero latency, in any cycle it requests outside DRAIN.
    assign w_vid_bus = (r_state == S_VIDEO) | (i_vid_req & (r_state != S_DRAIN));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        case (r_state)
            S_VIDEO:    if (!i_vid_req) w_state_nxt = S_DRAIN;
            S_DRAIN:    w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (i_vid_req) begin
                    w_state_nxt = S_VIDEO;
                end else if (i_aux_req && !i_vid_soon) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = i_aux_we ? S_WR_SETUP : S_AUX_RD;
                end
            end
            S_AUX_RD: begin
                if (i_aux_req && !i_aux_we && !i_vid_soon && !i_vid_req) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = S_AUX_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_SETUP: w_state_nxt = S_WR_PULSE;
            S_WR_PULSE: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (w_guard) begin
            w_gnt       = 1'b0;
            w_state_nxt = S_VIDEO;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_aux_addr  <= '0;
            r_aux_wdata <= '0;
            r_aux_rdata <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= (r_state == S_AUX_RD) & ~w_guard;
            r_err    <= r_err | w_guard;
            if ((r_state == S_AUX_RD) && !w_guard) begin
                r_aux_rdata <= i_sram_rdata;
            end
            if (w_gnt) begin
                r_aux_addr  <= i_aux_addr;
                r_aux_wdata <= i_aux_wdata;
            end
        end
    end

    assign o_vid_data   = i_sram_rdata;
    assign o_aux_gnt    = w_gnt;
    assign o_aux_rvalid = r_rvalid;
    assign o_aux_rdata  = r_aux_rdata;
    assign o_err        = r_err;

    assign o_sram_addr  = w_vid_bus ? i_vid_addr : r_aux_addr;
    assign o_sram_wdata = r_aux_wdata;
    assign o_sram_oe_n  = ~(w_vid_bus | (r_state == S_AUX_RD));
    assign o_sram_we_n  = ~(~w_vid_bus & (r_state == S_WR_PULSE));
    assign o_sram_dq_oe = ~w_vid_bus & ((r_state == S_WR_SETUP) | (r_state == S_WR_PULSE));

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Scoreboard bench for sram_access_scheduler with a behavioural SRAM whose
// unwritten words read as addr ^ 0xA5A5.
module tb_sram_access_scheduler;
    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          vid_req;
    logic          vid_soon;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          aux_req;
    logic          aux_we;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt;
    logic          aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic          err;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_dq_oe;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] mem [0:511];
    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    sram_access_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_vid_req(vid_req), .i_vid_soon(vid_soon), .i_vid_addr(vid_addr), .o_vid_data(vid_data),
        .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
        .o_aux_gnt(aux_gnt), .o_aux_rvalid(aux_rvalid), .o_aux_rdata(aux_rdata), .o_err(err),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_dq_oe(sram_dq_oe),
        .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n), .i_sram_rdata(sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign sram_rdata = mem[sram_addr[8:0]];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = DW'(i) ^ 16'hA5A5;
        forever begin
            @(negedge clk);
            if (!sram_we_n && sram_dq_oe) mem[sram_addr[8:0]] = sram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_read(input logic [DW-1:0] data);
        exp_t e;
        e.data = data;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (aux_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", 32'(aux_rdata), 32'(e.data));
                    check("rvalid_latency", cyc, e.cyc + 2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; vid_req = 1'b0; vid_soon = 1'b0; vid_addr = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
        #2;
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_wdata", 32'(sram_wdata), 32'd0);
        check("rst_gnt", 32'(aux_gnt), 32'd0);
        check("rst_rvalid", 32'(aux_rvalid), 32'd0);
        check("rst_rdata", 32'(aux_rdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Lookahead blocks a held aux request, then video for 8 cycles, then drain.
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 20'h00011;
        vid_soon = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("soon_no_gnt", 32'(aux_gnt), 32'd0);
            tick();
        end
        vid_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vid_addr = AW'(32'h100 + i);
            #1;
            check("vid_addr", 32'(sram_addr), 32'h100 + i);
            check("vid_oe_n", 32'(sram_oe_n), 32'd0);
            check("vid_data", 32'(vid_data), 32'((16'h0100 + 16'(i)) ^ 16'hA5A5));
            check("vid_no_gnt", 32'(aux_gnt), 32'd0);
            tick();
        end
        vid_req = 1'b0; vid_soon = 1'b0;
        #1 check("vid_fall_no_gnt", 32'(aux_gnt), 32'd0);
        tick();
        #1 check("drain_no_gnt", 32'(aux_gnt), 32'd0);
        check("drain_oe_n", 32'(sram_oe_n), 32'd1);
        tick();
        #1 check("post_drain_gnt", 32'(aux_gnt), 32'd1);
        if (aux_gnt) push_read(16'h0011 ^ 16'hA5A5);
        tick();
        aux_req = 1'b0;
        tick();
        tick();

        // Four back-to-back reads, then a write that must wait one turnaround cycle.
        for (int i = 0; i < 4; i++) begin
            aux_req = 1'b1; aux_we = 1'b0; aux_addr = AW'(32'h10 + i);
            #1 check("b2b_gnt", 32'(aux_gnt), 32'd1);
            if (aux_gnt) push_read((16'h0010 + 16'(i)) ^ 16'hA5A5);
            tick();
        end
        aux_we = 1'b1; aux_addr = 20'h00020; aux_wdata = 16'h1234;
        #1 check("rd2wr_no_gnt", 32'(aux_gnt), 32'd0);
        tick();
        #1 check("wr_gnt", 32'(aux_gnt), 32'd1);
        tick();
        aux_we = 1'b0; aux_addr = 20'h00020; aux_wdata = 16'h0000;
        #1;
        check("wr_setup_gnt", 32'(aux_gnt), 32'd0);
        check("wr_setup_we_n", 32'(sram_we_n), 32'd1);
        check("wr_setup_dq_oe", 32'(sram_dq_oe), 32'd1);
        check("wr_setup_addr", 32'(sram_addr), 32'h20);
        check("wr_setup_wdata", 32'(sram_wdata), 32'h1234);
        tick();
        #1;
        check("wr_pulse_gnt", 32'(aux_gnt), 32'd0);
        check("wr_pulse_we_n", 32'(sram_we_n), 32'd0);
        check("wr_pulse_wdata", 32'(sram_wdata), 32'h1234);
        tick();
        #1;
        check("wr_done_we_n", 32'(sram_we_n), 32'd1);
        check("wr_done_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("wr2rd_gnt", 32'(aux_gnt), 32'd1);
        if (aux_gnt) push_read(16'h1234);
        tick();
        aux_req = 1'b0;
        tick();
        tick();
        tick();

        // Video intrudes during an aux read: abort, no rvalid, sticky error.
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 20'h00012;
        #1 check("guard_rd_gnt", 32'(aux_gnt), 32'd1);
        tick();
        aux_req = 1'b0; vid_req = 1'b1; vid_addr = 20'h00155;
        #1;
        check("guard_addr", 32'(sram_addr), 32'h155);
        check("guard_oe_n", 32'(sram_oe_n), 32'd0);
        check("guard_err_pre", 32'(err), 32'd0);
        tick();
        vid_req = 1'b0;
        #1;
        check("guard_err", 32'(err), 32'd1);
        check("guard_no_rvalid", 32'(aux_rvalid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 check("err_sticky", 32'(err), 32'd1);
        end
        tick();

        // Asynchronous reset in the middle of the write pulse.
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 20'h00030; aux_wdata = 16'hBEEF;
        #1 check("rstwr_gnt", 32'(aux_gnt), 32'd1);
        tick();
        aux_req = 1'b0; aux_we = 1'b0;
        tick();
        #1 check("rstwr_pulse_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        check("rstwr_we_n", 32'(sram_we_n), 32'd1);
        check("rstwr_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rstwr_oe_n", 32'(sram_oe_n), 32'd1);
        check("rstwr_err", 32'(err), 32'd0);
        check("rstwr_addr", 32'(sram_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
